// File: rtl/pulse_monitor_pkg.sv
// Shared types and default constants for the pulse period monitor.
// Optional build macro: PULSE_MONITOR_SYNC_EN (2-flop input synchronizer).
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam int DEF_BIT_WIDTH   = 27;
  localparam int DEF_TIMEOUT_MAX = 100_000_000;
  localparam int MIN_PERIOD      = 2;

endpackage

// File: rtl/pulse_edge_sync.sv
// Input conditioning and rising-edge detect for the pulse period monitor.
// PULSE_MONITOR_SYNC_EN adds a 2-flop synchronizer ahead of the edge compare.
module pulse_edge_sync
  import pulse_monitor_pkg::*;
(
  input  logic clk,
  input  logic pulse_in,
  output logic pulse_edge
);

  logic in_s_q, in_s_d;
  logic in_prev_q, in_prev_d;

`ifdef PULSE_MONITOR_SYNC_EN
  logic sync1_q, sync1_d;

  always_comb begin
    sync1_d = pulse_in;
    in_s_d  = sync1_q;
  end

  always_ff @(posedge clk) begin
    sync1_q <= sync1_d;
  end
`else
  always_comb begin
    in_s_d = pulse_in;
  end
`endif

  // Not reset: the history keeps tracking the input so enabling on a high level is no edge.
  always_comb begin
    in_prev_d = in_s_q;
  end

  always_ff @(posedge clk) begin
    in_s_q    <= in_s_d;
    in_prev_q <= in_prev_d;
  end

  assign pulse_edge = in_s_q & ~in_prev_q;

endmodule

// File: rtl/pulse_period_monitor.sv
// Measures rising-to-rising interval of pulse_in in clk cycles, with timeout.
// Build macro PULSE_MONITOR_SYNC_EN selects the synchronized (one cycle slower) input path.
module pulse_period_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int TIMEOUT_MAX = DEF_TIMEOUT_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 pulse_in,
  output logic [BIT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 timeout,
  output logic                 measuring
);

  // A limit below the shortest legal interval would time out before any edge could land.
  localparam int TMAX_I = (TIMEOUT_MAX < MIN_PERIOD) ? MIN_PERIOD : TIMEOUT_MAX;
  localparam logic [BIT_WIDTH-1:0] TMAX_C = BIT_WIDTH'(TMAX_I);
  localparam logic [BIT_WIDTH-1:0] ONE_C  = BIT_WIDTH'(1);

  logic pulse_edge;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] count_q, count_d;
  logic [BIT_WIDTH-1:0] period_q, period_d;
  logic                 period_valid_q, period_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 measuring_q, measuring_d;

  pulse_edge_sync u_edge (
    .clk        (clk),
    .pulse_in   (pulse_in),
    .pulse_edge (pulse_edge)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    timeout_d      = timeout_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_edge) begin
            state_d = ST_MEASURE;
            count_d = ONE_C;
          end
        end
        ST_MEASURE: begin
          // An edge on the limit cycle still reports a valid TIMEOUT_MAX interval.
          if (pulse_edge) begin
            period_d       = count_q;
            period_valid_d = 1'b1;
            count_d        = ONE_C;
          end else if (count_q == TMAX_C) begin
            state_d   = ST_TIMEOUT;
            timeout_d = 1'b1;
          end else begin
            count_d = count_q + ONE_C;
          end
        end
        ST_TIMEOUT: begin
          if (pulse_edge) begin
            state_d   = ST_MEASURE;
            count_d   = ONE_C;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          count_d   = '0;
          timeout_d = 1'b0;
        end
      endcase
    end

    measuring_d = (state_d == ST_MEASURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      measuring_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      timeout_q      <= timeout_d;
      measuring_q    <= measuring_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign timeout      = timeout_q;
  assign measuring    = measuring_q;

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Self-checking bench for pulse_period_monitor: timestamp model plus directed literal checks.
module tb_pulse_period_monitor;

  localparam int BW = 27;
  localparam int TM = 20;
`ifdef PULSE_MONITOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b1;
  logic          pulse_in = 1'b0;
  logic [BW-1:0] period;
  logic          period_valid;
  logic          timeout;
  logic          measuring;

  pulse_period_monitor #(.BIT_WIDTH(BW), .TIMEOUT_MAX(TM)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
    .measuring    (measuring)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, exp);
    end
  endtask

  // Model: remember the cycle of the last accepted edge and derive outputs from timestamps.
  bit     hist [0:3];
  bit     m_meas = 0, m_to = 0, m_pv = 0;
  longint m_per = 0;
  int     m_last = 0;
  int     cyc = 0;

  int n_strobe = 0, last_period = -1, pv_cyc = -1, to_rise_cyc = -1, probe_cyc = -1;
  bit timeout_seen = 0, pv_consec = 0, prev_pv = 0, prev_to = 0;
  longint probe_per = -1;
  bit probe_pv = 0, probe_to = 0, probe_meas = 0;
  int last_n = 0;

  always @(posedge clk) begin
    cyc++;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pulse_in;
    if (reset || !enable) begin
      m_meas = 0; m_to = 0; m_pv = 0;
      if (reset) m_per = 0;
    end else if (hist[LAT] && !hist[LAT+1]) begin
      m_pv = m_meas;
      if (m_meas) m_per = cyc - m_last;
      m_last = cyc;
      m_meas = 1;
      m_to = 0;
    end else begin
      m_pv = 0;
      if (m_meas && (cyc - m_last) == TM) begin
        m_meas = 0;
        m_to = 1;
      end
    end
    #1;
    chk("period", period, m_per);
    chk("period_valid", period_valid, m_pv);
    chk("timeout", timeout, m_to);
    chk("measuring", measuring, m_meas);
    if (period_valid) begin
      n_strobe++;
      last_period = int'(period);
      pv_cyc = cyc;
      if (prev_pv) pv_consec = 1;
    end
    if (timeout && !prev_to) to_rise_cyc = cyc;
    if (timeout) timeout_seen = 1;
    prev_pv = period_valid;
    prev_to = timeout;
    if (cyc == probe_cyc) begin
      probe_per = period; probe_pv = period_valid; probe_to = timeout; probe_meas = measuring;
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      pulse_in = v;
    end
  endtask

  task automatic train(input int per, input int n);
    repeat (n) begin
      drive(1'b1, 1);
      last_n = cyc + 1;
      drive(1'b0, per - 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clr();
    n_strobe = 0; last_period = -1; timeout_seen = 0; pv_consec = 0;
  endtask

  initial begin
    int n1, n2;
    repeat (2) @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_measuring", measuring, 0);
    reset = 1'b0;
    drive(1'b0, 3);

    // Tick generator with COUNT_MAX=9: one-cycle pulse every 10 cycles
    clr();
    train(10, 6);
    chk("tick_strobes", n_strobe, 5);
    chk("tick_period", last_period, 10);
    chk("tick_no_timeout", timeout_seen, 0);
    do_reset();
    chk("rst_period2", period, 0);

    // Minimum spacing: 1,0,1,0...
    clr();
    repeat (5) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b0, 3);
    chk("min_strobes", n_strobe, 4);
    chk("min_period", last_period, 2);
    chk("min_no_consec", pv_consec, 0);
    do_reset();

    // Timeout and recovery
    clr();
    drive(1'b1, 1);
    n1 = cyc + 1;
    drive(1'b0, 30);
    chk("to_rise_cycle", to_rise_cyc, n1 + LAT + TM);
    chk("to_level", timeout, 1);
    drive(1'b1, 1);
    n1 = cyc + 1;
    probe_cyc = n1 + LAT;
    drive(1'b0, 6);
    drive(1'b1, 1);
    n2 = cyc + 1;
    drive(1'b0, 5);
    chk("recov_timeout", probe_to, 0);
    chk("recov_measuring", probe_meas, 1);
    chk("recov_no_strobe", probe_pv, 0);
    chk("recov_strobes", n_strobe, 1);
    chk("recov_period", last_period, 7);
    chk("latency", pv_cyc, n2 + LAT);
    do_reset();

    // Boundary: edges exactly TIMEOUT_MAX apart
    clr();
    train(20, 4);
    chk("bound_strobes", n_strobe, 3);
    chk("bound_period", last_period, 20);
    chk("bound_no_timeout", timeout_seen, 0);

    // Reset mid-interval
    drive(1'b1, 1);
    drive(1'b0, 5);
    chk("bound_period2", period, 20);
    @(negedge clk);
    reset = 1'b1;
    probe_cyc = cyc + 1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_period", probe_per, 0);
    chk("midrst_valid", probe_pv, 0);
    chk("midrst_timeout", probe_to, 0);
    chk("midrst_measuring", probe_meas, 0);

    // Disable with pulse_in held high, then re-enable
    drive(1'b0, 2);
    clr();
    train(8, 3);
    chk("en_strobes", n_strobe, 2);
    chk("en_period", last_period, 8);
    @(negedge clk);
    enable = 1'b0;
    pulse_in = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    drive(1'b1, 3);
    drive(1'b0, 5);
    chk("en_retained", period, 8);
    chk("en_no_false_edge", measuring, 0);
    chk("en_no_strobe", n_strobe, 2);
    clr();
    train(6, 3);
    chk("en_new_strobes", n_strobe, 2);
    chk("en_new_period", last_period, 6);
    chk("en_latency", pv_cyc, last_n + LAT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pulse_period_monitor.md
# pulse_period_monitor

Receive-side counterpart to the periodic tick generator. Watches a single-bit pulse train, recovers its rising edges and measures the interval between consecutive edges in `clk` cycles. Reports each completed interval with a one-cycle strobe and flags a timeout when the pulse train stops. Used to check tick sources and external pulse inputs on the computer board, and feeds the same 27-bit, 1-second-at-100 MHz timebase the generator uses.

## Interface
- `BIT_WIDTH`, 27: width of the interval counter and `period`.
- `TIMEOUT_MAX`, 100_000_000: largest interval, in cycles, before `timeout`. Must be < 2^BIT_WIDTH and ≥ 2.
- `clk` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high. Dominates every other input.
- `enable` in 1: low has the same effect as `reset`, except that `period` is retained.
- `pulse_in` in 1: monitored pulse train, active-high.
- `period` out BIT_WIDTH: last measured rising-to-rising interval in cycles. Reset value 0.
- `period_valid` out 1: one-cycle strobe when `period` updates. Reset value 0.
- `timeout` out 1: level, high while no edge has arrived within `TIMEOUT_MAX` cycles. Reset value 0.
- `measuring` out 1: high in the MEASURE state. Reset value 0.

## Operation
- **Edge detect:** `edge = in_s & ~in_prev`.
  - `in_s` is the conditioned input (see Configuration).
  - `in_prev` is `in_s` delayed by one cycle. It keeps updating during reset and while disabled, so enabling with `pulse_in` already high gives no edge.
- **States:** IDLE, MEASURE, TIMEOUT. IDLE is the reset state. Both reset and `enable=0` force IDLE, `count=0`, `period_valid=0` and `timeout=0`.
- **IDLE:** on `edge`, go to MEASURE and set `count<=1`. No strobe.
- **MEASURE:**
  - On `edge`: `period<=count`, `period_valid<=1`, `count<=1`.
  - Otherwise, if `count==TIMEOUT_MAX`: go to TIMEOUT and set `timeout<=1`.
  - Otherwise: `count<=count+1`.
- **TIMEOUT:** `count` is held. On `edge`, go to MEASURE, set `count<=1` and clear `timeout`. No strobe, because the interval is invalid.
- **Interval definition:** edges recognised in cycles a and b report `period=b-a`.
  - Minimum reportable value is 2 (high one cycle, low one cycle).
  - Maximum reportable value is `TIMEOUT_MAX`.
- **Arithmetic:** `count` never wraps. It saturates via the TIMEOUT transition, and `period` is an unsigned BIT_WIDTH value.
- **Simultaneous events:**
  - `edge` in the same cycle that `count==TIMEOUT_MAX`: the edge wins and reports `period=TIMEOUT_MAX`.
  - `reset` or `enable=0` arriving in the same cycle as `edge`: the edge is dropped.
- **Reset or disable mid-interval:** the partial count is discarded and there is no strobe. After reset, `period` reads 0. After a disable, `period` keeps its last value.
- **Strobe spacing:** `period_valid` is never high for two consecutive cycles.

## Timing
- Take N as the clock edge at which `pulse_in` is first sampled high, with the previous sample low.
  - Without the macro: `edge` occurs in the cycle after N. `period`, `period_valid` and the state update at N+1.
  - With the macro: they update at N+2.
- `pulse_in` must be high for at least 1 cycle and low for at least 1 cycle. With the synchronizer, pulses of 2 or more cycles are required to be guaranteed.
- `timeout` rises at the clock edge after the one at which `count` reached `TIMEOUT_MAX`. That is `TIMEOUT_MAX` cycles after the last edge.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
- `PULSE_MONITOR_SYNC_EN`:
  - **Defined:** `pulse_in` passes through a 2-flop synchronizer before edge detection. This is the asynchronous-input safe mode and adds 1 cycle of latency.
  - **Undefined:** `in_s` is `pulse_in` registered once. `pulse_in` must then be synchronous to `clk`, e.g. driven by the tick generator.
- The macro changes latency only. Measured `period` values are identical with and without it.

## Structure
- **`pulse_monitor_pkg`:**
  - State enum: IDLE, MEASURE, TIMEOUT.
  - Default constants: BIT_WIDTH 27, TIMEOUT_MAX 100_000_000.
  - Minimum period constant: 2.
- **Sub-module `pulse_edge_sync`:**
  - Contains the optional synchronizer, the `in_prev` register and the rising-edge compare.
  - Outputs: one-cycle `edge`.
  - The top level holds the FSM, counter and output registers.

## Test plan
- **Tick generator source:** generator with COUNT_MAX=9 drives `pulse_in`, with `TIMEOUT_MAX=50`. Expect the first edge to give no strobe, then `period_valid` every 10 cycles with `period=10`, and `timeout` staying 0.
- **Minimum spacing:** `pulse_in` toggles 1,0,1,0 each cycle (macro undefined). Expect `period=2` strobes on alternate cycles.
- **Timeout and recovery:** `TIMEOUT_MAX=20`. Give one edge, then hold low for 30 cycles.
  - Expect `timeout=1` 20 cycles after that edge.
  - On the next edge, expect `timeout=0`, `measuring=1` and no strobe.
  - On the following edge 7 cycles later, expect `period=7`.
- **Boundary:** edges exactly 20 cycles apart with `TIMEOUT_MAX=20`. Expect `period=20` and `timeout` never asserting.
- **Reset and disable:**
  - Assert `reset` mid-interval: expect all outputs 0 the next cycle.
  - Drop `enable` with `pulse_in` held high, then re-enable: expect no false edge, `period` retained, and the first new interval reported correctly.
- **Latency check:** run with and without `PULSE_MONITOR_SYNC_EN`. Expect `period_valid` at N+2 versus N+1, with identical `period` values.
